// File: rtl/router_pkg.sv
// Shared router types: flit format, flit labels, per-VC state and direction codes.
// Pure declarations; no latency, no flow control of its own.
package router_pkg;

  localparam int VC_BITS        = 2;
  localparam int NUM_VCS        = 1 << VC_BITS;
  localparam int DIM_BITS       = 4;
  localparam int DIRECTION_BITS = 3;
  localparam int PAYLOAD_BITS   = 16;

  localparam logic [DIRECTION_BITS-1:0] DIR_LOCAL = 3'd0;
  localparam logic [DIRECTION_BITS-1:0] DIR_N     = 3'd1;
  localparam logic [DIRECTION_BITS-1:0] DIR_E     = 3'd2;
  localparam logic [DIRECTION_BITS-1:0] DIR_S     = 3'd3;
  localparam logic [DIRECTION_BITS-1:0] DIR_W     = 3'd4;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTING = 2'd1,
    VA      = 2'd2,
    ACTIVE  = 2'd3
  } vc_state_t;

  typedef struct packed {
    flit_label_t              flit_label;
    logic [VC_BITS-1:0]       vc_id;
    logic [DIM_BITS-1:0]      dst_x;
    logic [DIM_BITS-1:0]      dst_y;
    logic [PAYLOAD_BITS-1:0]  payload;
  } flit_t;

  function automatic logic is_head(input flit_label_t lbl);
    return (lbl == HEAD) || (lbl == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_label_t lbl);
    return (lbl == TAIL) || (lbl == HEADTAIL);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC flit FIFO: a push is visible at data_o one cycle later; data_o reads 0 when empty.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module vc_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  flit_t data_i,
  input  logic  pop_i,
  output flit_t data_o,
  output logic  empty_o,
  output logic  full_o
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  flit_t                mem_q [DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr_q;
  logic [PTR_BITS-1:0]  rd_ptr_q;
  logic [CNT_BITS-1:0]  count_q;
  logic [CNT_BITS-1:0]  count_d;
  logic                 do_push;
  logic                 do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_BITS'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are exactly PTR_BITS wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Masking on empty keeps storage left over from before a reset off the outputs.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/input_unit.sv
// Router input port: per-VC FIFO + IDLE/ROUTING/VA/ACTIVE FSM; head reaches VA 2 cycles after write, credit 1 cycle after pop.
// Upstream is credit-controlled (overflow flits dropped); optional sticky err_o under INPUT_UNIT_ERR_EN.
module input_unit
  import router_pkg::*;
#(
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  flit_t                                   data_i,
  input  logic                                    valid_i,
  output logic [DIM_BITS-1:0]                     dst_x_o,
  output logic [DIM_BITS-1:0]                     dst_y_o,
  input  logic [DIRECTION_BITS-1:0]               rc_i,
  output logic [NUM_VCS-1:0][DIRECTION_BITS-1:0]  route_o,
  output logic [NUM_VCS-1:0]                      va_req_o,
  input  logic [NUM_VCS-1:0]                      va_grant_i,
  input  logic [NUM_VCS-1:0][VC_BITS-1:0]         va_vc_i,
  output logic [NUM_VCS-1:0][VC_BITS-1:0]         out_vc_o,
  output logic [NUM_VCS-1:0]                      sa_req_o,
  input  logic [NUM_VCS-1:0]                      sa_grant_i,
  output flit_t [NUM_VCS-1:0]                     flit_o,
  output logic                                    credit_valid_o,
  output logic [VC_BITS-1:0]                      credit_vc_o
`ifdef INPUT_UNIT_ERR_EN
  ,
  output logic                                    err_o
`endif
);

  vc_state_t                               state_q [NUM_VCS];
  logic [NUM_VCS-1:0][DIRECTION_BITS-1:0]  route_q;
  logic [NUM_VCS-1:0][VC_BITS-1:0]         out_vc_q;
  logic                                    credit_valid_q;
  logic [VC_BITS-1:0]                      credit_vc_q;

  logic [NUM_VCS-1:0] push;
  logic [NUM_VCS-1:0] pop;
  logic [NUM_VCS-1:0] empty;
  logic [NUM_VCS-1:0] full;
  logic               rt_vld;
  logic [VC_BITS-1:0] rt_sel;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign push[v] = valid_i && (data_i.vc_id == VC_BITS'(v)) && (!full[v] || pop[v]);
    assign pop[v]  = sa_grant_i[v] && (state_q[v] == ACTIVE) && !empty[v];

    assign va_req_o[v] = (state_q[v] == VA);
    assign sa_req_o[v] = (state_q[v] == ACTIVE) && !empty[v];

    vc_fifo #(
      .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[v]),
      .data_i  (data_i),
      .pop_i   (pop[v]),
      .data_o  (flit_o[v]),
      .empty_o (empty[v]),
      .full_o  (full[v])
    );
  end

  // Single route-computation port: lowest-index VC in ROUTING wins, others wait.
  always_comb begin
    rt_vld = 1'b0;
    rt_sel = '0;
    for (int v = NUM_VCS - 1; v >= 0; v--) begin
      if (state_q[v] == ROUTING) begin
        rt_vld = 1'b1;
        rt_sel = VC_BITS'(v);
      end
    end
  end

  assign dst_x_o = rt_vld ? flit_o[rt_sel].dst_x : '0;
  assign dst_y_o = rt_vld ? flit_o[rt_sel].dst_y : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) state_q[v] <= IDLE;
      route_q        <= '0;
      out_vc_q       <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
    end else begin
      credit_valid_q <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) begin
        case (state_q[v])
          IDLE: begin
            if (!empty[v] && is_head(flit_o[v].flit_label)) state_q[v] <= ROUTING;
          end
          ROUTING: begin
            if (rt_vld && (rt_sel == VC_BITS'(v))) begin
              route_q[v] <= rc_i;
              state_q[v] <= VA;
            end
          end
          VA: begin
            if (va_grant_i[v]) begin
              out_vc_q[v] <= va_vc_i[v];
              state_q[v]  <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (pop[v]) begin
              credit_valid_q <= 1'b1;
              credit_vc_q    <= VC_BITS'(v);
              if (is_tail(flit_o[v].flit_label)) state_q[v] <= IDLE;
            end
          end
          default: state_q[v] <= IDLE;
        endcase
      end
    end
  end

  assign route_o        = route_q;
  assign out_vc_o       = out_vc_q;
  assign credit_valid_o = credit_valid_q;
  assign credit_vc_o    = credit_vc_q;

`ifdef INPUT_UNIT_ERR_EN
  logic err_q;
  logic err_evt;

  always_comb begin
    err_evt = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (valid_i && (data_i.vc_id == VC_BITS'(v)) && full[v] && !pop[v]) err_evt = 1'b1;
      if (sa_grant_i[v] && !pop[v]) err_evt = 1'b1;
      if ((state_q[v] == IDLE) && !empty[v] && !is_head(flit_o[v].flit_label)) err_evt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | err_evt;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_input_unit.sv
// Directed bench for input_unit: expected credits and route events are queued by the
// stimulus and consumed by a negedge monitor; other checks are made inline.
module tb_input_unit;
  import router_pkg::*;

  logic                                    clk;
  logic                                    rst;
  flit_t                                   data_i;
  logic                                    valid_i;
  logic [DIM_BITS-1:0]                     dst_x_o;
  logic [DIM_BITS-1:0]                     dst_y_o;
  logic [DIRECTION_BITS-1:0]               rc_i;
  logic [NUM_VCS-1:0][DIRECTION_BITS-1:0]  route_o;
  logic [NUM_VCS-1:0]                      va_req_o;
  logic [NUM_VCS-1:0]                      va_grant_i;
  logic [NUM_VCS-1:0][VC_BITS-1:0]         va_vc_i;
  logic [NUM_VCS-1:0][VC_BITS-1:0]         out_vc_o;
  logic [NUM_VCS-1:0]                      sa_req_o;
  logic [NUM_VCS-1:0]                      sa_grant_i;
  flit_t [NUM_VCS-1:0]                     flit_o;
  logic                                    credit_valid_o;
  logic [VC_BITS-1:0]                      credit_vc_o;
`ifdef INPUT_UNIT_ERR_EN
  logic                                    err_o;
`endif

  input_unit #(.BUFFER_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .dst_x_o        (dst_x_o),
    .dst_y_o        (dst_y_o),
    .rc_i           (rc_i),
    .route_o        (route_o),
    .va_req_o       (va_req_o),
    .va_grant_i     (va_grant_i),
    .va_vc_i        (va_vc_i),
    .out_vc_o       (out_vc_o),
    .sa_req_o       (sa_req_o),
    .sa_grant_i     (sa_grant_i),
    .flit_o         (flit_o),
    .credit_valid_o (credit_valid_o),
    .credit_vc_o    (credit_vc_o)
`ifdef INPUT_UNIT_ERR_EN
    ,
    .err_o          (err_o)
`endif
  );

  typedef struct {
    int                        vc;
    logic [DIRECTION_BITS-1:0] route;
    logic [DIM_BITS-1:0]       dx;
    logic [DIM_BITS-1:0]       dy;
  } route_exp_t;

  int                 checks = 0;
  int                 errors = 0;
  logic [VC_BITS-1:0] cred_q[$];
  route_exp_t         route_q[$];
  logic [NUM_VCS-1:0] va_prev = '0;
  logic [DIM_BITS-1:0] prev_dx = '0;
  logic [DIM_BITS-1:0] prev_dy = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External XY route computation for a router sitting at (1,1).
  function automatic logic [DIRECTION_BITS-1:0] route_fn(input logic [DIM_BITS-1:0] x,
                                                         input logic [DIM_BITS-1:0] y);
    if (x > 1)      return DIR_E;
    else if (x < 1) return DIR_W;
    else if (y > 1) return DIR_N;
    else if (y < 1) return DIR_S;
    else            return DIR_LOCAL;
  endfunction

  always_comb rc_i = route_fn(dst_x_o, dst_y_o);

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input int vc, input flit_label_t lbl, input logic [DIM_BITS-1:0] dx,
                           input logic [DIM_BITS-1:0] dy, input logic [15:0] pl);
    data_i.flit_label = lbl;
    data_i.vc_id      = VC_BITS'(vc);
    data_i.dst_x      = dx;
    data_i.dst_y      = dy;
    data_i.payload    = pl;
    valid_i           = 1'b1;
    tick();
    valid_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic exp_route(input int vc, input logic [DIRECTION_BITS-1:0] r,
                           input logic [DIM_BITS-1:0] dx, input logic [DIM_BITS-1:0] dy);
    route_exp_t e;
    e.vc = vc; e.route = r; e.dx = dx; e.dy = dy;
    route_q.push_back(e);
  endtask

  task automatic grant_va(input int vc, input int ovc);
    int n = 0;
    while (!va_req_o[vc] && n < 20) begin
      tick();
      n++;
    end
    chk("va_req_wait", 128'(va_req_o[vc]), 128'd1);
    va_grant_i[vc] = 1'b1;
    va_vc_i[vc]    = VC_BITS'(ovc);
    tick();
    va_grant_i = '0;
    va_vc_i    = '0;
    chk("out_vc", 128'(out_vc_o[vc]), 128'(ovc));
    chk("va_req_after_grant", 128'(va_req_o[vc]), 128'd0);
  endtask

  task automatic pop(input int vc, input logic [15:0] pl);
    chk("sa_req_before_pop", 128'(sa_req_o[vc]), 128'd1);
    chk("front_payload", 128'(flit_o[vc].payload), 128'(pl));
    sa_grant_i[vc] = 1'b1;
    cred_q.push_back(VC_BITS'(vc));
    tick();
    sa_grant_i = '0;
    chk("credit_valid_next_cycle", 128'(credit_valid_o), 128'd1);
    chk("credit_vc_next_cycle", 128'(credit_vc_o), 128'(vc));
  endtask

  // Scoreboard monitor: credits and VA entries are matched against queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      va_prev = '0;
    end else begin
      if (credit_valid_o) begin
        if (cred_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_credit: got vc %0d expected none at %0t", credit_vc_o, $time);
        end else begin
          logic [VC_BITS-1:0] e;
          e = cred_q.pop_front();
          chk("mon_credit_vc", 128'(credit_vc_o), 128'(e));
        end
      end
      for (int v = 0; v < NUM_VCS; v++) begin
        if (va_req_o[v] && !va_prev[v]) begin
          if (route_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_route: got vc %0d routed expected none at %0t", v, $time);
          end else begin
            route_exp_t r;
            r = route_q.pop_front();
            chk("mon_route_vc", 128'(v), 128'(r.vc));
            chk("mon_route_o", 128'(route_o[v]), 128'(r.route));
            chk("mon_dst_x", 128'(prev_dx), 128'(r.dx));
            chk("mon_dst_y", 128'(prev_dy), 128'(r.dy));
          end
        end
      end
      va_prev = va_req_o;
      prev_dx = dst_x_o;
      prev_dy = dst_y_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    valid_i    = 1'b0;
    data_i     = '0;
    va_grant_i = '0;
    va_vc_i    = '0;
    sa_grant_i = '0;
    #3;
    chk("rst_va_req", 128'(va_req_o), 128'd0);
    chk("rst_sa_req", 128'(sa_req_o), 128'd0);
    chk("rst_route", 128'(route_o), 128'd0);
    chk("rst_out_vc", 128'(out_vc_o), 128'd0);
    chk("rst_credit", 128'(credit_valid_o), 128'd0);
    chk("rst_flit_o", 128'(flit_o), 128'd0);
    chk("rst_dst_x", 128'(dst_x_o), 128'd0);
`ifdef INPUT_UNIT_ERR_EN
    chk("rst_err", 128'(err_o), 128'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // HEADTAIL to VC0, dst (2,1) -> E; VA two cycles after the write.
    exp_route(0, DIR_E, 4'd2, 4'd1);
    push_flit(0, HEADTAIL, 4'd2, 4'd1, 16'h0101);
    chk("t1_va_req_write", 128'(va_req_o[0]), 128'd0);
    tick();
    chk("t1_dst_x", 128'(dst_x_o), 128'd2);
    chk("t1_dst_y", 128'(dst_y_o), 128'd1);
    chk("t1_va_req_1cyc", 128'(va_req_o[0]), 128'd0);
    tick();
    chk("t1_va_req_2cyc", 128'(va_req_o[0]), 128'd1);
    chk("t1_route", 128'(route_o[0]), 128'(DIR_E));
    grant_va(0, 3);
    sa_grant_i = 4'b1000;
    tick();
    sa_grant_i = '0;
    chk("t1_ignored_grant_credit", 128'(credit_valid_o), 128'd0);
`ifdef INPUT_UNIT_ERR_EN
    chk("t1_err_ignored_grant", 128'(err_o), 128'd1);
`endif
    pop(0, 16'h0101);
    tick();
    chk("t1_idle_va", 128'(va_req_o[0]), 128'd0);
    chk("t1_idle_sa", 128'(sa_req_o[0]), 128'd0);

    // Heads on VC0 then VC1 back to back: VC0 routed first, VC1 one cycle later.
    exp_route(0, DIR_N, 4'd1, 4'd3);
    exp_route(1, DIR_W, 4'd0, 4'd2);
    push_flit(0, HEADTAIL, 4'd1, 4'd3, 16'h0201);
    push_flit(1, HEADTAIL, 4'd0, 4'd2, 16'h0202);
    chk("t2_dst_x_vc0", 128'(dst_x_o), 128'd1);
    chk("t2_dst_y_vc0", 128'(dst_y_o), 128'd3);
    tick();
    chk("t2_va_req_vc0", 128'(va_req_o[1:0]), 128'd1);
    chk("t2_dst_x_vc1", 128'(dst_x_o), 128'd0);
    chk("t2_dst_y_vc1", 128'(dst_y_o), 128'd2);
    tick();
    chk("t2_va_req_both", 128'(va_req_o[1:0]), 128'd3);
    grant_va(0, 1);
    grant_va(1, 0);
    pop(0, 16'h0201);
    pop(1, 16'h0202);

    // Four-flit packet on VC1 granted downstream VC 2.
    exp_route(1, DIR_S, 4'd1, 4'd0);
    push_flit(1, HEAD, 4'd1, 4'd0, 16'h1100);
    push_flit(1, BODY, 4'd0, 4'd0, 16'h1101);
    push_flit(1, BODY, 4'd0, 4'd0, 16'h1102);
    push_flit(1, TAIL, 4'd0, 4'd0, 16'h1103);
    grant_va(1, 2);
    chk("t3_out_vc1", 128'(out_vc_o[1]), 128'd2);
    pop(1, 16'h1100);
    pop(1, 16'h1101);
    pop(1, 16'h1102);
    pop(1, 16'h1103);
    tick();
    tick();
    chk("t3_vc1_idle_va", 128'(va_req_o[1]), 128'd0);
    chk("t3_vc1_idle_sa", 128'(sa_req_o[1]), 128'd0);

    // Non-head flit at the front of an idle VC is held, never routed.
    push_flit(3, BODY, 4'd3, 4'd3, 16'h3300);
    repeat (3) tick();
    chk("t4_body_not_routed", 128'(va_req_o[3]), 128'd0);
    chk("t4_body_held", 128'(flit_o[3].payload), 128'h3300);

    // Overflow of VC0, then push+pop on the full VC, then another dropped push.
    exp_route(0, DIR_E, 4'd3, 4'd3);
    push_flit(0, HEAD, 4'd3, 4'd3, 16'h0A01);
    push_flit(0, BODY, 4'd0, 4'd0, 16'h0A02);
    push_flit(0, BODY, 4'd0, 4'd0, 16'h0A03);
    push_flit(0, TAIL, 4'd0, 4'd0, 16'h0A04);
    push_flit(0, HEADTAIL, 4'd2, 4'd2, 16'h0A05);
`ifdef INPUT_UNIT_ERR_EN
    chk("t5_err_overflow", 128'(err_o), 128'd1);
`endif
    grant_va(0, 1);
    chk("t5_front_before_pushpop", 128'(flit_o[0].payload), 128'h0A01);
    exp_route(0, DIR_LOCAL, 4'd1, 4'd1);
    cred_q.push_back(2'd0);
    data_i.flit_label = HEADTAIL;
    data_i.vc_id      = 2'd0;
    data_i.dst_x      = 4'd1;
    data_i.dst_y      = 4'd1;
    data_i.payload    = 16'h0A06;
    valid_i           = 1'b1;
    sa_grant_i[0]     = 1'b1;
    tick();
    valid_i    = 1'b0;
    data_i     = '0;
    sa_grant_i = '0;
    chk("t5_pushpop_credit", 128'(credit_valid_o), 128'd1);
    push_flit(0, BODY, 4'd0, 4'd0, 16'h0A07);
    pop(0, 16'h0A02);
    pop(0, 16'h0A03);
    pop(0, 16'h0A04);
    grant_va(0, 0);
    pop(0, 16'h0A06);
    tick();
    chk("t5_vc0_empty_flit", 128'(flit_o[0]), 128'd0);
    chk("t5_vc0_empty_sa", 128'(sa_req_o[0]), 128'd0);

    // Reset while VC2 is ACTIVE with two flits and a credit just issued.
    exp_route(2, DIR_N, 4'd1, 4'd2);
    push_flit(2, HEAD, 4'd1, 4'd2, 16'h2201);
    push_flit(2, BODY, 4'd0, 4'd0, 16'h2202);
    push_flit(2, TAIL, 4'd0, 4'd0, 16'h2203);
    grant_va(2, 1);
    pop(2, 16'h2201);
    chk("t6_active_sa", 128'(sa_req_o[2]), 128'd1);
    sa_grant_i[2] = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b1;
    sa_grant_i = '0;
    #1;
    chk("t6_rst_credit", 128'(credit_valid_o), 128'd0);
    chk("t6_rst_credit_vc", 128'(credit_vc_o), 128'd0);
    chk("t6_rst_va_req", 128'(va_req_o), 128'd0);
    chk("t6_rst_sa_req", 128'(sa_req_o), 128'd0);
    chk("t6_rst_route", 128'(route_o), 128'd0);
    chk("t6_rst_out_vc", 128'(out_vc_o), 128'd0);
    chk("t6_rst_flit_o", 128'(flit_o), 128'd0);
    chk("t6_rst_dst_x", 128'(dst_x_o), 128'd0);
`ifdef INPUT_UNIT_ERR_EN
    chk("t6_rst_err", 128'(err_o), 128'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) tick();
    chk("t6_post_rst_credit", 128'(credit_valid_o), 128'd0);
    chk("t6_post_rst_flit_o", 128'(flit_o), 128'd0);
    chk("t6_post_rst_va_req", 128'(va_req_o), 128'd0);

    chk("pending_credits", 128'(cred_q.size()), 128'd0);
    chk("pending_routes", 128'(route_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
